// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the central sequencer.
// The sequencer takes the master side: it drives the stall/flush/redirect
// controls and watches the stall requests and redirect events.
interface pipe_ctrl_if;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        branch_flag_i;
    logic [31:0] branch_addr_i;
    logic        excp_req_i;
    logic [31:0] excp_vec_i;
    logic        mret_req_i;
    logic [31:0] epc_i;
    logic [5:0]  stalled;
    logic [5:0]  flush;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        timeout_o;

    modport master (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  branch_flag_i, branch_addr_i, excp_req_i, excp_vec_i,
        input  mret_req_i, epc_i,
        output stalled, flush, redirect_o, redirect_pc_o, timeout_o
    );

    modport slave (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output branch_flag_i, branch_addr_i, excp_req_i, excp_vec_i,
        output mret_req_i, epc_i,
        input  stalled, flush, redirect_o, redirect_pc_o, timeout_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer for the 5-stage core.
// Bit k of stalled/flush maps to PC,IF,ID,EX,MEM,WB for k=0..5.
// A trap (exception or mret) redirects the PC and is followed by a single
// DRAIN cycle that kills whatever was fetched while the trap was taken.
// Stall/flush/redirect are combinational; only the FSM and the stall
// watchdog counter are registered.
module pipe_ctrl #(
    parameter int STALL_TIMEOUT = 255,
    parameter int CNT_W         = 8
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.master  bus
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_stallCnt;

    logic [5:0]  w_stallVec;
    logic [5:0]  w_stalled;
    logic [5:0]  w_flush;
    logic        w_redirect;
    logic [31:0] w_redirectPc;
    logic        w_timeout;
    logic        w_trap;
    logic        w_anyStalled;

    // Deepest stage requesting a stall wins and freezes everything upstream of it
    always_comb begin
        w_stallVec = 6'b000000;
        if (bus.stallreq_mem) begin
            w_stallVec = 6'b011111;
        end else if (bus.stallreq_ex) begin
            w_stallVec = 6'b001111;
        end else if (bus.stallreq_id) begin
            w_stallVec = 6'b000111;
        end else if (bus.stallreq_if) begin
            w_stallVec = 6'b000011;
        end
    end

    // Trap beats mret beats branch/stall; a branch waits while EX itself is frozen
    always_comb begin
        w_stalled    = 6'b000000;
        w_flush      = 6'b000000;
        w_redirect   = 1'b0;
        w_redirectPc = 32'h0000_0000;
        w_trap       = 1'b0;
        if (r_state == DRAIN) begin
            w_flush = 6'b000110;
        end else if (bus.excp_req_i) begin
            w_trap       = 1'b1;
            w_flush      = 6'b011110;
            w_redirect   = 1'b1;
            w_redirectPc = bus.excp_vec_i;
        end else if (bus.mret_req_i) begin
            w_trap       = 1'b1;
            w_flush      = 6'b011110;
            w_redirect   = 1'b1;
            w_redirectPc = bus.epc_i;
        end else if (bus.branch_flag_i && !w_stallVec[3]) begin
            w_flush      = 6'b000110;
            w_redirect   = 1'b1;
            w_redirectPc = bus.branch_addr_i;
        end else begin
            w_stalled = w_stallVec;
        end
    end

    assign w_anyStalled = |w_stalled;

    // Watchdog fires only on the cycle the count steps onto the threshold
    assign w_timeout = w_anyStalled && (r_stallCnt == CNT_W'(STALL_TIMEOUT - 1));

    // Outputs fall to their idle values the instant reset is asserted
    always_comb begin
        bus.stalled       = rst ? w_stalled    : 6'b000000;
        bus.flush         = rst ? w_flush      : 6'b000000;
        bus.redirect_o    = rst ? w_redirect   : 1'b0;
        bus.redirect_pc_o = rst ? w_redirectPc : 32'h0000_0000;
        bus.timeout_o     = rst ? w_timeout    : 1'b0;
    end

    // Trap FSM plus saturating consecutive-stall counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= RUN;
            r_stallCnt <= '0;
        end else begin
            case (r_state)
                RUN:     r_state <= w_trap ? DRAIN : RUN;
                DRAIN:   r_state <= RUN;
                default: r_state <= RUN;
            endcase
            if (!w_anyStalled) begin
                r_stallCnt <= '0;
            end else if (r_stallCnt != '1) begin
                r_stallCnt <= r_stallCnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl. Inputs change just after the rising
// edge; outputs are sampled on the falling edge.
module tb_pipe_ctrl;

    logic clk;
    logic rst;
    int   nChecks;
    int   nFails;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.STALL_TIMEOUT(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 ns core clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the bench can never hang
    initial begin
        #100000;
        $display("[TB] FAIL watchdog_timeout: simulation exceeded time limit");
        $fatal(1, "[TB] time limit");
    end

    task automatic clearInputs();
        bus.stallreq_if   = 1'b0;
        bus.stallreq_id   = 1'b0;
        bus.stallreq_ex   = 1'b0;
        bus.stallreq_mem  = 1'b0;
        bus.branch_flag_i = 1'b0;
        bus.branch_addr_i = 32'h0;
        bus.excp_req_i    = 1'b0;
        bus.excp_vec_i    = 32'h0;
        bus.mret_req_i    = 1'b0;
        bus.epc_i         = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clearInputs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        nChecks++;
        if (bus.stalled !== 6'b0 || bus.flush !== 6'b0 || bus.redirect_o !== 1'b0 || bus.timeout_o !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset_outputs: stalled=%b flush=%b redirect=%b timeout=%b, required all zero",
                     bus.stalled, bus.flush, bus.redirect_o, bus.timeout_o);
        end
    endtask

    task automatic test_stall();
        logic [5:0] expVec [4];
        expVec[0] = 6'b011111;
        expVec[1] = 6'b001111;
        expVec[2] = 6'b000111;
        expVec[3] = 6'b000011;
        tick();
        bus.stallreq_mem = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            nChecks++;
            if (bus.stalled !== 6'b011111) begin
                nFails++;
                $display("[TB] FAIL stall_mem_cycle%0d: stalled=%b required 011111", c, bus.stalled);
            end
            tick();
        end
        bus.stallreq_mem = 1'b0;
        @(negedge clk);
        nChecks++;
        if (bus.stalled !== 6'b0) begin
            nFails++;
            $display("[TB] FAIL stall_release: stalled=%b required 000000", bus.stalled);
        end
        // Each requester alone, deepest first; all four together picks mem
        for (int k = 0; k < 4; k++) begin
            tick();
            clearInputs();
            bus.stallreq_mem = (k == 0);
            bus.stallreq_ex  = (k == 1);
            bus.stallreq_id  = (k == 2);
            bus.stallreq_if  = (k == 3);
            @(negedge clk);
            nChecks++;
            if (bus.stalled !== expVec[k] || bus.flush !== 6'b0) begin
                nFails++;
                $display("[TB] FAIL stall_single%0d: stalled=%b flush=%b required %b / 000000",
                         k, bus.stalled, bus.flush, expVec[k]);
            end
        end
        tick();
        bus.stallreq_mem = 1'b1;
        bus.stallreq_ex  = 1'b1;
        bus.stallreq_id  = 1'b1;
        bus.stallreq_if  = 1'b1;
        @(negedge clk);
        nChecks++;
        if (bus.stalled !== 6'b011111) begin
            nFails++;
            $display("[TB] FAIL stall_priority: stalled=%b required 011111", bus.stalled);
        end
        tick();
        clearInputs();
    endtask

    task automatic test_branch();
        tick();
        bus.branch_flag_i = 1'b1;
        bus.branch_addr_i = 32'h0000_0100;
        @(negedge clk);
        nChecks++;
        if (bus.flush !== 6'b000110 || bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'h100 || bus.stalled !== 6'b0) begin
            nFails++;
            $display("[TB] FAIL branch_taken: flush=%b redirect=%b pc=%h stalled=%b, required 000110/1/00000100/000000",
                     bus.flush, bus.redirect_o, bus.redirect_pc_o, bus.stalled);
        end
        tick();
        bus.stallreq_ex = 1'b1;
        @(negedge clk);
        nChecks++;
        if (bus.redirect_o !== 1'b0 || bus.stalled !== 6'b001111 || bus.flush !== 6'b0) begin
            nFails++;
            $display("[TB] FAIL branch_held_ex: redirect=%b stalled=%b flush=%b, required 0/001111/000000",
                     bus.redirect_o, bus.stalled, bus.flush);
        end
        tick();
        bus.stallreq_ex  = 1'b0;
        bus.stallreq_mem = 1'b1;
        @(negedge clk);
        nChecks++;
        if (bus.redirect_o !== 1'b0 || bus.stalled !== 6'b011111) begin
            nFails++;
            $display("[TB] FAIL branch_held_mem: redirect=%b stalled=%b, required 0/011111",
                     bus.redirect_o, bus.stalled);
        end
        tick();
        bus.stallreq_mem = 1'b0;
        bus.stallreq_id  = 1'b1;
        bus.branch_addr_i = 32'h0000_0240;
        @(negedge clk);
        nChecks++;
        if (bus.redirect_o !== 1'b1 || bus.stalled !== 6'b0 || bus.redirect_pc_o !== 32'h240 || bus.flush !== 6'b000110) begin
            nFails++;
            $display("[TB] FAIL branch_over_id: redirect=%b stalled=%b pc=%h flush=%b, required 1/000000/00000240/000110",
                     bus.redirect_o, bus.stalled, bus.redirect_pc_o, bus.flush);
        end
        tick();
        clearInputs();
    endtask

    task automatic test_exception();
        tick();
        bus.excp_req_i    = 1'b1;
        bus.excp_vec_i    = 32'h0000_0080;
        bus.stallreq_mem  = 1'b1;
        bus.branch_flag_i = 1'b1;
        bus.branch_addr_i = 32'h0000_0100;
        @(negedge clk);
        nChecks++;
        if (bus.flush !== 6'b011110 || bus.stalled !== 6'b0 || bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'h80) begin
            nFails++;
            $display("[TB] FAIL excp_cycle: flush=%b stalled=%b redirect=%b pc=%h, required 011110/000000/1/00000080",
                     bus.flush, bus.stalled, bus.redirect_o, bus.redirect_pc_o);
        end
        tick();
        @(negedge clk);
        nChecks++;
        if (bus.flush !== 6'b000110 || bus.stalled !== 6'b0 || bus.redirect_o !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL excp_drain: flush=%b stalled=%b redirect=%b, required 000110/000000/0",
                     bus.flush, bus.stalled, bus.redirect_o);
        end
        tick();
        clearInputs();
        bus.branch_flag_i = 1'b1;
        bus.branch_addr_i = 32'h0000_0100;
        @(negedge clk);
        nChecks++;
        if (bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'h100) begin
            nFails++;
            $display("[TB] FAIL excp_back_to_run: redirect=%b pc=%h, required 1/00000100",
                     bus.redirect_o, bus.redirect_pc_o);
        end
        tick();
        clearInputs();
    endtask

    task automatic test_mret();
        tick();
        bus.mret_req_i = 1'b1;
        bus.epc_i      = 32'h0000_2004;
        @(negedge clk);
        nChecks++;
        if (bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'h2004 || bus.flush !== 6'b011110) begin
            nFails++;
            $display("[TB] FAIL mret_cycle: redirect=%b pc=%h flush=%b, required 1/00002004/011110",
                     bus.redirect_o, bus.redirect_pc_o, bus.flush);
        end
        tick();
        @(negedge clk);
        nChecks++;
        if (bus.flush !== 6'b000110 || bus.redirect_o !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL mret_drain: flush=%b redirect=%b, required 000110/0", bus.flush, bus.redirect_o);
        end
        tick();
        bus.excp_req_i = 1'b1;
        bus.excp_vec_i = 32'h0000_0080;
        @(negedge clk);
        nChecks++;
        if (bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'h80) begin
            nFails++;
            $display("[TB] FAIL excp_over_mret: redirect=%b pc=%h, required 1/00000080",
                     bus.redirect_o, bus.redirect_pc_o);
        end
        tick();
        clearInputs();
        tick();
    endtask

    task automatic test_watchdog();
        logic expTo;
        bus.stallreq_if = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            expTo = (c == 4);
            @(negedge clk);
            nChecks++;
            if (bus.timeout_o !== expTo) begin
                nFails++;
                $display("[TB] FAIL timeout_first_cycle%0d: timeout=%b required %b", c, bus.timeout_o, expTo);
            end
            tick();
        end
        bus.stallreq_if = 1'b0;
        @(negedge clk);
        nChecks++;
        if (bus.timeout_o !== 1'b0 || bus.stalled !== 6'b0) begin
            nFails++;
            $display("[TB] FAIL timeout_gap: timeout=%b stalled=%b, required 0/000000", bus.timeout_o, bus.stalled);
        end
        tick();
        bus.stallreq_if = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            expTo = (c == 4);
            @(negedge clk);
            nChecks++;
            if (bus.timeout_o !== expTo) begin
                nFails++;
                $display("[TB] FAIL timeout_second_cycle%0d: timeout=%b required %b", c, bus.timeout_o, expTo);
            end
            tick();
        end
        clearInputs();
    endtask

    task automatic test_reset_mid_trap();
        tick();
        bus.excp_req_i = 1'b1;
        bus.excp_vec_i = 32'h0000_0080;
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        nChecks++;
        if (bus.flush !== 6'b0 || bus.redirect_o !== 1'b0 || bus.redirect_pc_o !== 32'h0 || bus.stalled !== 6'b0) begin
            nFails++;
            $display("[TB] FAIL reset_mid_trap: flush=%b redirect=%b pc=%h stalled=%b, required all zero",
                     bus.flush, bus.redirect_o, bus.redirect_pc_o, bus.stalled);
        end
        tick();
        rst = 1'b1;
        clearInputs();
        bus.branch_flag_i = 1'b1;
        bus.branch_addr_i = 32'h0000_0300;
        @(negedge clk);
        nChecks++;
        if (bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'h300) begin
            nFails++;
            $display("[TB] FAIL reset_state_run: redirect=%b pc=%h, required 1/00000300",
                     bus.redirect_o, bus.redirect_pc_o);
        end
        tick();
        clearInputs();
    endtask

    // Scenario sequence followed by the summary line
    initial begin
        nChecks = 0;
        nFails  = 0;
        test_reset();
        test_stall();
        test_branch();
        test_exception();
        test_mret();
        test_watchdog();
        test_reset_mid_trap();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
